// File: rtl/pio_poll_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pio_poll_pkg
// Purpose  : Shared types and sizing helpers for the Avalon PIO poll master.
// Revision : 1.0 - initial release
// ============================================================================
package pio_poll_pkg;

    // Poll sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        UPD  = 2'd3
    } state_t;

    // Width of the accepted-sample counter
    localparam int SAMPLE_CNT_W = 16;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Widths for the default parameter set
    localparam int DEF_TMR_W = cnt_w(50000);
    localparam int DEF_TO_W  = cnt_w(255);
    localparam int DEF_LAT_W = cnt_w(1);

endpackage : pio_poll_pkg
`default_nettype wire

// File: rtl/avalon_pio_poll_master_poll_timer.sv
`default_nettype none
// ============================================================================
// Module   : poll_timer
// Purpose  : Free-running reloadable down-counter; o_tick is high while the
//            count sits at zero, and the count reloads DIV-1 on that cycle.
// Revision : 1.0 - initial release
// ============================================================================
module poll_timer
    import pio_poll_pkg::*;
#(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    output logic o_tick
);

    localparam int               c_TMR_W  = cnt_w(DIV);
    localparam logic [c_TMR_W-1:0] c_RELOAD = c_TMR_W'(DIV - 1);

    logic [c_TMR_W-1:0] r_count;

    // Count down every cycle, reloading after reaching zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= c_RELOAD;
        end else if (r_count == '0) begin
            r_count <= c_RELOAD;
        end else begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tick = (r_count == '0);

endmodule : poll_timer
`default_nettype wire

// File: rtl/avalon_pio_poll_master.sv
`default_nettype none
// ============================================================================
// Module   : avalon_pio_poll_master
// Purpose  : Avalon-MM read master that periodically samples a PIO data
//            register, holds the masked value, pulses 'changed' and raises a
//            sticky irq on a new value. Abandoned reads set timeout_err.
//            Optional macro POLL_DEBOUNCE_EN: a value is accepted only after
//            DEB_COUNT consecutive equal samples.
// Revision : 1.0 - initial release
// ============================================================================
module avalon_pio_poll_master
    import pio_poll_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter logic [ADDR_W-1:0] TARGET_ADDR  = '0,
    parameter int                POLL_DIV     = 50000,
    parameter int                READ_LATENCY = 1,
    parameter int                TIMEOUT      = 255,
    parameter logic [DATA_W-1:0] SAMPLE_MASK  = {DATA_W{1'b1}}
`ifdef POLL_DEBOUNCE_EN
    ,
    parameter int                DEB_COUNT    = 3
`endif
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    output logic [ADDR_W-1:0]       avm_address,
    output logic                    avm_read,
    input  logic                    avm_waitrequest,
    input  logic [DATA_W-1:0]       avm_readdata,
    output logic [DATA_W-1:0]       value,
    output logic                    changed,
    output logic                    irq,
    input  logic                    irq_clear,
    output logic                    timeout_err,
    output logic [SAMPLE_CNT_W-1:0] sample_cnt
);

    localparam int                 c_TO_W     = cnt_w(TIMEOUT);
    localparam int                 c_LAT_W    = cnt_w(READ_LATENCY);
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT - 1);
    localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'(READ_LATENCY - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_tick;
    logic                    w_accept;
    logic                    w_timeout;
    logic                    w_capture;
    logic                    w_update;
    logic [c_TO_W-1:0]       r_to_cnt;
    logic [c_LAT_W-1:0]      r_lat_cnt;
    logic [DATA_W-1:0]       r_sample;
    logic [DATA_W-1:0]       r_value;
    logic                    r_irq;
    logic                    r_terr;
    logic [SAMPLE_CNT_W-1:0] r_cnt;

    poll_timer #(
        .DIV     (POLL_DIV)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .o_tick  (w_tick)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next-state decode and per-cycle transaction events
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_timeout = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            IDLE: if (w_tick && enable) w_next = REQ;
            REQ: begin
                if (!avm_waitrequest) begin
                    w_accept = 1'b1;
                    w_next   = WAIT;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end
            end
            WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_capture = 1'b1;
                    w_next    = UPD;
                end
            end
            UPD:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Stall counter while in REQ and read-latency counter while in WAIT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt  <= '0;
            r_lat_cnt <= '0;
        end else begin
            if (r_state == REQ && avm_waitrequest && !w_timeout) r_to_cnt <= r_to_cnt + 1'b1;
            else                                                  r_to_cnt <= '0;
            if (w_accept)                                    r_lat_cnt <= c_LAT_LAST;
            else if (r_state == WAIT && r_lat_cnt != '0)     r_lat_cnt <= r_lat_cnt - 1'b1;
        end
    end

    // Capture the masked read data when the latency expires
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       r_sample <= '0;
        else if (w_capture) r_sample <= avm_readdata & SAMPLE_MASK;
    end

`ifdef POLL_DEBOUNCE_EN
    localparam int                 c_RUN_W = cnt_w(DEB_COUNT + 1);
    localparam logic [c_RUN_W-1:0] c_DEB   = c_RUN_W'(DEB_COUNT);

    logic [DATA_W-1:0]  r_cand;
    logic [c_RUN_W-1:0] r_run;
    logic [c_RUN_W-1:0] w_run_next;

    // Run length of equal samples, saturating at the debounce count
    always_comb begin
        w_run_next = c_RUN_W'(1);
        if (r_sample == r_cand) w_run_next = (r_run == c_DEB) ? c_DEB : r_run + 1'b1;
    end

    // The candidate always becomes the latest sample; only the run resets
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cand <= '0;
            r_run  <= '0;
        end else if (r_state == UPD) begin
            r_cand <= r_sample;
            r_run  <= w_run_next;
        end
    end

    assign w_update = (r_state == UPD) && (w_run_next == c_DEB) && (r_sample != r_value);
`else
    assign w_update = (r_state == UPD) && (r_sample != r_value);
`endif

    // Accepted-sample count and held value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_value <= '0;
        end else if (r_state == UPD) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_update) r_value <= r_sample;
        end
    end

    // Sticky flags: a new event in the same cycle as irq_clear wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq  <= 1'b0;
            r_terr <= 1'b0;
        end else begin
            if (w_update)       r_irq <= 1'b1;
            else if (irq_clear) r_irq <= 1'b0;
            if (w_timeout)      r_terr <= 1'b1;
            else if (irq_clear) r_terr <= 1'b0;
        end
    end

    // The new value is forwarded during UPD so it appears with 'changed'
    assign value       = w_update ? r_sample : r_value;
    assign changed     = w_update;
    assign avm_read    = (r_state == REQ);
    assign avm_address = TARGET_ADDR;
    assign irq         = r_irq;
    assign timeout_err = r_terr;
    assign sample_cnt  = r_cnt;

endmodule : avalon_pio_poll_master
`default_nettype wire
